// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle MIPS-style datapath
// Ports: clk/rst (async active-high), opcode/zero in; datapath controls, illegal and state out.
// Define MULTICYCLE_JAL_EN to enable the JAL state (opcode 000011); otherwise it decodes as illegal.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ANDI_EXEC = 4'd11,
    I_WB      = 4'd12,
    JAL       = 4'd13
  } state_t;
  state_t r_state, w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  assign state = r_state;
  always_comb begin
    w_next     = FETCH;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_en     = 1'b1;
        alu_src_b = 2'b01;
        w_next    = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000:           w_next = R_EXEC;
          6'b100011, 6'b101011: w_next = MEM_ADDR;
          6'b000100:           w_next = BRANCH;
          6'b000010:           w_next = JUMP;
          6'b001000:           w_next = ADDI_EXEC;
          6'b001100:           w_next = ANDI_EXEC;
`ifdef MULTICYCLE_JAL_EN
          6'b000011:           w_next = JAL;
`endif
          default:             illegal = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == 6'b100011) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        w_next   = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        w_next    = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
        w_next    = I_WB;
      end
      ANDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b100;
        w_next    = I_WB;
      end
      I_WB: reg_write = 1'b1;
`ifdef MULTICYCLE_JAL_EN
      JAL: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        pc_src     = 2'b10;
        pc_en      = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction streams checked against a per-instruction reference model
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, alu_src_a, reg_write, illegal;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [18:0] act;
  int n_cmp = 0;
  int n_err = 0;
  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  assign act = {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, alu_src_a,
                alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};
  function automatic logic legal(input logic [5:0] op);
`ifdef MULTICYCLE_JAL_EN
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0c, 6'h03};
`else
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0c};
`endif
  endfunction
  function automatic logic [18:0] exp_out(input int st, input logic [5:0] op, input logic z);
    logic pe, iod, mr, mw, irw, asa, rw, ill;
    logic [1:0] ps, asb, rd, m2r;
    logic [2:0] aop;
    {pe, iod, mr, mw, irw, asa, rw, ill} = '0;
    {ps, asb, rd, m2r} = '0;
    aop = '0;
    case (st)
      0:  begin mr = 1; irw = 1; pe = 1; asb = 2'b01; end
      1:  begin asb = 2'b11; ill = !legal(op); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 3'b010; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 3'b001; ps = 2'b01; pe = z; end
      9:  begin ps = 2'b10; pe = 1; end
      10: begin asa = 1; asb = 2'b10; aop = 3'b011; end
      11: begin asa = 1; asb = 2'b10; aop = 3'b100; end
      12: rw = 1;
`ifdef MULTICYCLE_JAL_EN
      13: begin rw = 1; rd = 2'b10; m2r = 2'b10; ps = 2'b10; pe = 1; end
`endif
      default: ;
    endcase
    return {pe, ps, iod, mr, mw, irw, asa, asb, aop, rw, rd, m2r, ill};
  endfunction
  task automatic run_instr(input logic [5:0] op, input bit rand_zero, input logic zfix);
    int q[$];
    case (op)
      6'h23:   q = '{0, 1, 2, 3, 4};
      6'h2b:   q = '{0, 1, 2, 5};
      6'h00:   q = '{0, 1, 6, 7};
      6'h04:   q = '{0, 1, 8};
      6'h02:   q = '{0, 1, 9};
      6'h08:   q = '{0, 1, 10, 12};
      6'h0c:   q = '{0, 1, 11, 12};
`ifdef MULTICYCLE_JAL_EN
      6'h03:   q = '{0, 1, 13};
`endif
      default: q = '{0, 1};
    endcase
    opcode = op;
    foreach (q[i]) begin
      zero = rand_zero ? 1'($urandom_range(0, 1)) : zfix;
      #1;
      n_cmp++;
      if (state !== 4'(q[i])) begin
        n_err++;
        $display("FAIL state op=%b step %0d: got %0d want %0d", op, i, state, q[i]);
      end
      n_cmp++;
      if (act !== exp_out(q[i], op, zero)) begin
        n_err++;
        $display("FAIL outputs op=%b step %0d zero=%b: got %b want %b", op, i, zero, act, exp_out(q[i], op, zero));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (state !== 4'd0) begin
      n_err++;
      $display("FAIL end_state op=%b: got %0d want 0", op, state);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; opcode = 6'h23; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (state !== 4'd0 || act !== exp_out(0, opcode, zero)) begin
      n_err++;
      $display("FAIL reset_hold: got state %0d out %b want 0 %b", state, act, exp_out(0, opcode, zero));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 4'd1) begin
      n_err++;
      $display("FAIL reset_release: got %0d want 1", state);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic test_reset_mid();
    opcode = 6'h23;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (state !== 4'd3) begin
      n_err++;
      $display("FAIL mid_reach_memrd: got %0d want 3", state);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (state !== 4'd0) begin
      n_err++;
      $display("FAIL mid_async_reset: got %0d want 0", state);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++;
      if (reg_write !== 1'b0 || state !== 4'd0) begin
        n_err++;
        $display("FAIL mid_no_wb: got state %0d reg_write %b want 0 0", state, reg_write);
      end
    end
    rst = 1'b0;
    run_instr(6'h23, 1, 0);
  endtask
  task automatic test_branch();
    run_instr(6'h04, 0, 1'b0);
    run_instr(6'h04, 0, 1'b1);
  endtask
  task automatic test_random();
    logic [5:0] ops [8] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0c, 6'h03};
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) run_instr(6'($urandom), 1, 0);
      else run_instr(ops[$urandom_range(0, 7)], 1, 0);
    end
  endtask
  initial begin
    test_reset();
    run_instr(6'h23, 1, 0);
    run_instr(6'h00, 1, 0);
    test_branch();
    run_instr(6'h3f, 1, 0);
    run_instr(6'h03, 1, 0);
    run_instr(6'h2b, 1, 0);
    run_instr(6'h08, 1, 0);
    run_instr(6'h0c, 1, 0);
    run_instr(6'h02, 1, 0);
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  sole clock, rising edge; rst  input  1  asynchronous, active-high reset.
REQ-002 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-003 zero  input  1  ALU zero flag.
REQ-004 pc_en  output  1  PC load enable.
REQ-005 pc_src  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-006 i_or_d  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-007 mem_read  output  1  memory read strobe.
REQ-008 mem_write  output  1  memory write strobe.
REQ-009 ir_write  output  1  instruction register load.
REQ-010 alu_src_a  output  1  ALU A select: 0 PC, 1 register A.
REQ-011 alu_src_b  output  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
REQ-012 alu_op  output  3  drives the ALU control decoder: 000 add, 001 sub, 010 R-type by func, 011 addi, 100 andi.
REQ-013 reg_write  output  1  register file write enable.
REQ-014 reg_dst  output  2  destination select: 00 rt, 01 rd, 10 register 31.
REQ-015 mem_to_reg  output  2  write-back data select: 00 ALUOut, 01 MDR, 10 PC.
REQ-016 illegal  output  1  unrecognised opcode in DECODE.
REQ-017 state  output  4  current state encoding, for debug.

Function
REQ-018 The block SHALL be a Moore FSM; outputs derive from the state register only, except pc_en in BRANCH and illegal in DECODE.
REQ-019 Outputs not listed for a state SHALL be 0.
REQ-020 Encodings SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ANDI_EXEC 11, I_WB 12, JAL 13.
REQ-021 FETCH: mem_read, ir_write, pc_en = 1; alu_src_b = 01; alu_op = 000; next state DECODE.
REQ-022 DECODE: alu_src_b = 11; alu_op = 000; next state by opcode: 000000 R_EXEC, 100011/101011 MEM_ADDR, 000100 BRANCH, 000010 JUMP, 001000 ADDI_EXEC, 001100 ANDI_EXEC, 000011 JAL (per REQ-035).
REQ-023 DECODE, any other opcode: illegal = 1 for that cycle; next state FETCH.
REQ-024 MEM_ADDR: alu_src_a = 1; alu_src_b = 10; alu_op = 000; next state MEM_RD if opcode is 100011, else MEM_WR.
REQ-025 MEM_RD: mem_read, i_or_d = 1; next state MEM_WB.
REQ-026 MEM_WB: reg_write = 1; mem_to_reg = 01; reg_dst = 00; next state FETCH.
REQ-027 MEM_WR: mem_write, i_or_d = 1; next state FETCH.
REQ-028 R_EXEC: alu_src_a = 1; alu_src_b = 00; alu_op = 010; next state R_WB. R_WB: reg_write = 1; reg_dst = 01; next state FETCH.
REQ-029 BRANCH: alu_src_a = 1; alu_op = 001; pc_src = 01; pc_en = zero (combinational); next state FETCH.
REQ-030 JUMP: pc_src = 10; pc_en = 1; next state FETCH.
REQ-031 ADDI_EXEC and ANDI_EXEC: alu_src_a = 1; alu_src_b = 10; alu_op 011 / 100 respectively; next state I_WB. I_WB: reg_write = 1; reg_dst = 00; next state FETCH.
REQ-032 Cycles per instruction SHALL be: lw 5; sw, R-type, addi, andi 4; beq, j, jal 3.
REQ-033 Unused state encodings (14, 15) SHALL transition to FETCH with all outputs 0.

Reset
REQ-034 While rst = 1, the state SHALL be FETCH asynchronously; the first rising clk edge after deassertion SHALL advance to DECODE; reset mid-instruction SHALL abandon the instruction with no further writes.

Configuration
REQ-035 With MULTICYCLE_JAL_EN defined, opcode 000011 SHALL enter JAL: reg_write = 1; reg_dst = 10; mem_to_reg = 10; pc_src = 10; pc_en = 1; next state FETCH. Without MULTICYCLE_JAL_EN, opcode 000011 SHALL be illegal per REQ-023, and state 13 SHALL be treated per REQ-033.

Verification
REQ-036 Release rst, opcode = 100011 -> states 0,1,2,3,4,0; mem_to_reg = 01 and reg_write = 1 only in state 4.
REQ-037 opcode = 000000 -> states 0,1,6,7,0; alu_op = 010 in state 6; reg_dst = 01 in state 7.
REQ-038 opcode = 000100 with zero = 0, then zero = 1 -> pc_en = 0, then 1 in state 8; alu_op = 001.
REQ-039 opcode = 111111 -> illegal = 1 in DECODE only, then state 0; reg_write and mem_write stay 0.
REQ-040 opcode = 000011 -> states 0,1,13,0 with reg_dst = 10 when MULTICYCLE_JAL_EN is defined; otherwise illegal = 1 and states 0,1,0.
REQ-041 Assert rst during MEM_RD of lw -> state = 0 immediately; no reg_write pulse follows.
